// File: rtl/interval_capture.sv
// -----------------------------------------------------------------------------
// interval_capture
//
// Measures the number of clock cycles between a start pulse and a stop pulse
// and presents the result through a valid/ready handshake. It is the inverse
// of a loadable down-counter: a timed interval goes in, a value comes out.
//
// Ports
//   clk        in   1      system clock, rising-edge active
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      single-cycle pulse that begins (or restarts) a
//                          measurement
//   stop       in   1      single-cycle pulse that ends a measurement
//   out_ready  in   1      consumer accepts the presented result
//   value      out  WIDTH  captured interval in cycles, saturated to
//                          2^WIDTH-1
//   overflow   out  1      captured interval exceeded 2^WIDTH-1
//   valid      out  1      value/overflow hold a result not yet accepted
//   busy       out  1      a measurement is in progress
//
// Behaviour summary
//   IDLE : start -> RUN with cnt cleared; stop alone is ignored; a start and
//          a stop in the same cycle behave like start alone.
//   RUN  : stop captures cnt+1 (saturated) and moves to HOLD; stop wins over
//          a simultaneous start. Otherwise start restarts the count from zero
//          and a quiet cycle increments cnt, saturating at 2^WIDTH-1.
//   HOLD : valid is high; start/stop are ignored; valid && out_ready returns
//          to IDLE. A start on the acceptance edge is therefore dropped.
//
// Timing: start sampled at edge k and stop sampled at edge k+N yield value=N
// visible together with valid right after edge k+N. All outputs are driven
// straight from flops.
// -----------------------------------------------------------------------------
module interval_capture #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             out_ready,
    output logic [WIDTH-1:0] value,
    output logic             overflow,
    output logic             valid,
    output logic             busy
);

    // Largest representable interval; the counter parks here instead of wrapping.
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             valid_q;
    logic             valid_d;
    logic             busy_q;
    logic             busy_d;

    // One extra bit so that cnt_q == CNT_MAX still produces a visible carry.
    logic [WIDTH:0]   cnt_plus1_s;

    // Saturating increment of the running count.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        if (x == CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = x + WIDTH'(1'b1);
        end
        return r;
    endfunction

    // Reduce a WIDTH+1 bit sum to the saturated WIDTH-bit result.
    function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH:0] sum);
        logic [WIDTH-1:0] r;
        if (sum[WIDTH]) begin
            r = CNT_MAX;
        end else begin
            r = sum[WIDTH-1:0];
        end
        return r;
    endfunction

    // The interval reported on stop includes the stop cycle itself, hence +1.
    always_comb begin
        cnt_plus1_s = {1'b0, cnt_q} + (WIDTH + 1)'(1'b1);
    end

    // Next-state, counter and capture logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        value_d    = value_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous stop; stop alone does nothing.
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // stop has priority over a simultaneous start (restart).
                if (stop) begin
                    value_d    = sat_result(cnt_plus1_s);
                    overflow_d = cnt_plus1_s[WIDTH];
                    state_d    = ST_HOLD;
                end else if (start) begin
                    cnt_d = CNT_ZERO;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            ST_HOLD: begin
                // valid is implied by HOLD, so out_ready alone completes the transfer.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Status flags are decoded from the next state so they leave a flop.
    always_comb begin
        valid_d = (state_d == ST_HOLD);
        busy_d  = (state_d == ST_RUN);
    end

    // State, counter, result and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            value_q    <= CNT_ZERO;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign value    = value_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_interval_capture.sv
// -----------------------------------------------------------------------------
// tb_interval_capture
//
// Self-checking bench for interval_capture. A reference model tracks, in edge
// numbers, when the current measurement began and turns a stop into
// min(N, 2^W-1) / (N > 2^W-1) with plain arithmetic. Directed tasks check the
// scenarios from the block description against constants; a randomized task
// compares every cycle against the model.
// -----------------------------------------------------------------------------
module tb_interval_capture;

    localparam int W    = 5;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         out_ready;
    logic [W-1:0] value;
    logic         overflow;
    logic         valid;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Reference model: measurement in progress, result waiting, start edge, result.
    bit m_active;
    bit m_pending;
    bit m_ovf;
    int m_start_edge;
    int m_value;

    always #5 clk = ~clk;

    interval_capture #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .out_ready (out_ready),
        .value     (value),
        .overflow  (overflow),
        .valid     (valid),
        .busy      (busy)
    );

    function automatic void model_reset();
        m_active     = 1'b0;
        m_pending    = 1'b0;
        m_ovf        = 1'b0;
        m_value      = 0;
        m_start_edge = 0;
    endfunction

    // Drive one cycle of inputs, advance the model by one edge, sample at edge+1.
    task automatic cycle(input bit s, input bit p, input bit r);
        int n;
        start     = s;
        stop      = p;
        out_ready = r;
        @(posedge clk);
        edge_no++;
        if (rst_n) begin
            if (m_pending) begin
                if (r) m_pending = 1'b0;
            end else if (m_active) begin
                if (p) begin
                    n         = edge_no - m_start_edge;
                    m_value   = (n > MAXV) ? MAXV : n;
                    m_ovf     = (n > MAXV);
                    m_pending = 1'b1;
                    m_active  = 1'b0;
                end else if (s) begin
                    m_start_edge = edge_no;
                end
            end else if (s) begin
                m_active     = 1'b1;
                m_start_edge = edge_no;
            end
        end
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        model_reset();
        #22;
        checks++; if (value !== 5'd0)    begin errors++; $display("FAIL reset_value: got %0d expected 0", value); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL basic_busy: got busy=%b valid=%b expected busy=1 valid=0", busy, valid); end
            cycle(1'b0, 1'b0, 1'b1);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_last: got %b expected 1", busy); end
        cycle(1'b0, 1'b1, 1'b1);
        checks++; if (value !== 5'd7)    begin errors++; $display("FAIL basic_value: got %0d expected 7", value); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
        checks++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_hold: got valid=%b busy=%b expected valid=1 busy=0", valid, busy); end
        cycle(1'b0, 1'b0, 1'b1);
        checks++; if (valid !== 1'b0 || value !== 5'd7) begin errors++; $display("FAIL basic_accept: got valid=%b value=%0d expected valid=0 value=7", valid, value); end
    endtask

    task automatic test_min_sat();
        int n_tab[4]   = '{1, 31, 32, 40};
        int v_tab[4]   = '{1, 31, 31, 31};
        bit o_tab[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 4; t++) begin
            cycle(1'b1, 1'b0, 1'b1);
            for (int i = 1; i < n_tab[t]; i++) cycle(1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b1, 1'b1);
            checks++; if (value !== v_tab[t][W-1:0] || overflow !== o_tab[t] || valid !== 1'b1)
                begin errors++; $display("FAIL minsat_n%0d: got value=%0d ovf=%b valid=%b expected value=%0d ovf=%b valid=1", n_tab[t], value, overflow, valid, v_tab[t], o_tab[t]); end
            cycle(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        bit s_tab[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bit p_tab[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++; if (valid !== 1'b1 || value !== 5'd5 || busy !== 1'b0)
                begin errors++; $display("FAIL bp_hold%0d: got valid=%b value=%0d busy=%b expected valid=1 value=5 busy=0", i, valid, value, busy); end
            cycle(s_tab[i], p_tab[i], 1'b0);
        end
        checks++; if (valid !== 1'b1 || value !== 5'd5) begin errors++; $display("FAIL bp_hold_end: got valid=%b value=%0d expected valid=1 value=5", valid, value); end
        // start on the acceptance edge must be dropped
        cycle(1'b1, 1'b0, 1'b1);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_accept: got valid=%b busy=%b expected 0 0", valid, busy); end
        cycle(1'b0, 1'b0, 1'b1);
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || value !== 5'd5) begin errors++; $display("FAIL bp_idle: got busy=%b valid=%b value=%0d expected 0 0 5", busy, valid, value); end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 1'b1, 1'b1);
        checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL sim_idle_both: got busy=%b valid=%b expected 1 0", busy, valid); end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        checks++; if (value !== 5'd3 || valid !== 1'b1) begin errors++; $display("FAIL sim_restart: got value=%0d valid=%b expected 3 1", value, valid); end
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        checks++; if (value !== 5'd6 || valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sim_run_both: got value=%0d valid=%b busy=%b expected 6 1 0", value, valid, busy); end
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stray();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            checks++; if (value !== 5'd6 || overflow !== 1'b0 || valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL stray%0d: got value=%0d ovf=%b valid=%b busy=%b expected 6 0 0 0", i, value, overflow, valid, busy); end
        end
    endtask

    task automatic measure9(input string tag);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checks++; if (value !== 5'd9 || valid !== 1'b1 || overflow !== 1'b0)
            begin errors++; $display("FAIL %s: got value=%0d valid=%b ovf=%b expected 9 1 0", tag, value, valid, overflow); end
    endtask

    task automatic test_async_reset();
        // abort in RUN
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({valid, busy, overflow, value} !== 8'd0) begin errors++; $display("FAIL arst_run: got valid=%b busy=%b ovf=%b value=%0d expected all 0", valid, busy, overflow, value); end
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        measure9("arst_meas_after_run");
        // abort in HOLD (with a prior overflowing result not relevant: value is 9)
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({valid, busy, overflow, value} !== 8'd0) begin errors++; $display("FAIL arst_hold: got valid=%b busy=%b ovf=%b value=%0d expected all 0", valid, busy, overflow, value); end
        cycle(1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        measure9("arst_meas_after_hold");
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [W+2:0] exp_v;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(15) == 0), ($urandom_range(23) == 0), ($urandom_range(2) != 0));
            exp_v = {m_pending, m_active, m_ovf, m_value[W-1:0]};
            checks++; if ({valid, busy, overflow, value} !== exp_v)
                begin errors++; $display("FAIL random_c%0d: got valid=%b busy=%b ovf=%b value=%0d expected valid=%b busy=%b ovf=%b value=%0d",
                                         i, valid, busy, overflow, value, m_pending, m_active, m_ovf, m_value); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_sat();
        test_backpressure();
        test_simultaneous();
        test_stray();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
